hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and multiplier-occupancy controller for the five-stage pipelined processor (`pp`). It sequences the IF/ID/ALU pipeline registers and the PC by driving the `pcHold`, `ifHold`, `idHold`, `ifKill`, `idKill` and `aluKill` signals. It resolves load-use hazards, taken branches, and contention for the shared iterative multiplier. It also tracks multiplier occupancy with a countdown state machine and keeps a stall-cycle performance counter.

## Interface
- `MULT_CYCLES`, default 32: number of cycles the iterative multiplier is busy per `mult`/`multu`; legal range is ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `regRst`  in  1  reset, asynchronous and active-low.
- `idRs`, `idRt`  in  5 each  source register numbers of the instruction in ID.
- `idUsesRs`, `idUsesRt`  in  1 each  ID instruction actually reads `rs` / `rt`.
- `idMult`  in  1  ID holds `mult`/`multu`.
- `idReadsHiLo`  in  1  ID holds `mfhi`/`mflo`.
- `aluMemRd`  in  1  ALU-stage instruction is a load.
- `aluRegWr`  in  1  ALU-stage instruction writes the register file.
- `aluRw`  in  5  ALU-stage destination register.
- `aluBranchTaken`  in  1  branch or jump resolved taken in the ALU stage.
- `pcHold`, `ifHold`, `idHold`  out  1 each  freeze the PC and the IF/ID pipeline registers.
- `ifKill`, `idKill`, `aluKill`  out  1 each  load a bubble (nop) into the named stage register.
- `multStart`  out  1  single-cycle pulse that launches the multiplier.
- `multBusy`  out  1  multiplier is occupied; HI/LO are not valid.
- `stallCount`  out  32  number of cycles in which `pcHold` was asserted.

## Operation
- State machine: IDLE and BUSY. `cnt` has width `$clog2(MULT_CYCLES+1)`. `multBusy = (cnt != 0)`.
- Load-use hazard, `luHaz`: `aluMemRd & aluRegWr & aluRw != 0 & ((idUsesRs & idRs == aluRw) | (idUsesRt & idRt == aluRw))`. ALU/MEM forwarding is handled outside this block, so a one-cycle bubble is sufficient.
- Multiplier hazard, `mHaz`: `multBusy & (idReadsHiLo | idMult)`.
- Priority 1, `aluBranchTaken`: `ifKill = idKill = 1`. All holds are 0 and `aluKill = 0`, so the PC loads the target. The ID instruction is squashed, so `multStart = 0` even if `idMult` is high. An in-flight multiply (an older instruction) continues counting.
- Priority 2, `luHaz | mHaz` with no branch: `pcHold = ifHold = idHold = 1`, `aluKill = 1`, all other kills 0, `multStart = 0`.
- Priority 3, `idMult & !multBusy` with no branch and no hazard: `multStart = 1`, no holds or kills. On the edge, `cnt <= MULT_CYCLES` and the state moves to BUSY.
- In BUSY, `cnt` decrements by 1 every cycle regardless of stalls or kills. When `cnt` reaches 0 the state is IDLE.
- `stallCount` increments by 1 on every edge where `pcHold = 1`. It wraps from `0xFFFFFFFF` to 0.
- All hazard outputs and `multStart` are combinational from the inputs and `cnt`. They are forced to 0 while `regRst` is low.

## Timing
- Reset (`regRst` low, asynchronous): `cnt = 0`, state IDLE, `stallCount = 0`. `multBusy`, `multStart`, all holds and all kills are 0. Release takes effect on the first rising edge after `regRst` goes high.
- Load-use stall lasts exactly one cycle. The next cycle the load has left ALU, so `luHaz` deasserts.
- If `multStart` fires in cycle T, `multBusy` is 1 in cycles T+1 through T+`MULT_CYCLES` and 0 at T+`MULT_CYCLES`+1. An `mfhi` held in ID is released in cycle T+`MULT_CYCLES`+1.
- Back-to-back `mult`: the second one stalls until `multBusy` falls, then pulses `multStart` in that same cycle.
- With `MULT_CYCLES = 1`, `multBusy` is high for exactly one cycle.
- Simultaneous branch and hazard: the branch wins with no holds, and `stallCount` does not increment.
- Reset asserted mid-multiply: `cnt` clears immediately and `multBusy` drops without waiting for a clock.

## Test plan
- Reset: hold `regRst = 0` with random inputs → all outputs 0 and `stallCount = 0`. Release it and drive all inputs 0 → outputs stay 0.
- Load-use: `aluMemRd = 1`, `aluRegWr = 1`, `aluRw = 5`, `idRs = 5`, `idUsesRs = 1` for one cycle → `pcHold = ifHold = idHold = aluKill = 1` for exactly 1 cycle and `stallCount = 1`. Repeat with `aluRw = 0` → no stall.
- Multiply sequence, `MULT_CYCLES = 4`: `idMult = 1` in cycle 0 → `multStart = 1` in cycle 0 and `multBusy = 1` in cycles 1–4. `idReadsHiLo = 1` from cycle 1 → holds in cycles 1–4, released in cycle 5, `stallCount = 4`.
- Branch over mult: `idMult = 1` with `aluBranchTaken = 1` → `ifKill = idKill = 1`, `multStart = 0`, `multBusy` stays 0.
- Branch during a stall condition: `luHaz` and `aluBranchTaken` in the same cycle → kills only, no holds, `stallCount` unchanged.
- Mid-multiply reset: pulse `regRst` low asynchronously at cycle 2 of a multiply → `multBusy` falls before the next edge. After release, a new `idMult` starts a full `MULT_CYCLES` window.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and multiplier-occupancy controller for the five-stage
// pipelined processor. Decides, every cycle, whether the PC and the IF/ID
// pipeline registers freeze and which stage registers receive a bubble.
// Also launches the shared iterative multiplier and tracks its occupancy.
// Counts stall cycles for performance monitoring.
//
// Ports
//   clk            system clock, rising-edge
//   regRst         asynchronous active-low reset
//   idRs, idRt     source registers of the ID-stage instruction
//   idUsesRs/Rt    ID instruction really reads rs / rt
//   idMult         ID holds mult/multu
//   idReadsHiLo    ID holds mfhi/mflo
//   aluMemRd       ALU-stage instruction is a load
//   aluRegWr       ALU-stage instruction writes the register file
//   aluRw          ALU-stage destination register
//   aluBranchTaken branch/jump resolved taken in ALU
//   pcHold/ifHold/idHold   freeze PC, IF and ID registers
//   ifKill/idKill/aluKill  load a bubble into the named stage register
//   multStart      one-cycle multiplier launch pulse
//   multBusy       multiplier occupied; HI/LO not valid
//   stallCount     number of cycles with pcHold asserted (wraps)
//   dbgState       occupancy FSM state (0 = IDLE, 1 = BUSY)
//
// Multiplier handshake: multStart is the launch strobe and multBusy is the
// "not ready" flag. A launch is accepted only in a cycle where multBusy is
// low, and it is taken on that same rising edge; from the next cycle
// multBusy stays high for exactly MULT_CYCLES cycles. No launch is ever
// issued while multBusy is high, so a second mult waits in ID instead.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        regRst,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idUsesRs,
  input  logic        idUsesRt,
  input  logic        idMult,
  input  logic        idReadsHiLo,
  input  logic        aluMemRd,
  input  logic        aluRegWr,
  input  logic [4:0]  aluRw,
  input  logic        aluBranchTaken,
  output logic        pcHold,
  output logic        ifHold,
  output logic        idHold,
  output logic        ifKill,
  output logic        idKill,
  output logic        aluKill,
  output logic        multStart,
  output logic        multBusy,
  output logic [31:0] stallCount,
  output logic        dbgState
);

  localparam int CW = $clog2(MULT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cntNext;

  logic rsMatch;
  logic rtMatch;
  logic luHaz;
  logic mHaz;

  assign multBusy = (cnt != '0);
  assign dbgState = (state == BUSY);

  // Register 0 is hard-wired zero, so a load "to" r0 never creates a hazard.
  assign rsMatch = idUsesRs && (idRs == aluRw);
  assign rtMatch = idUsesRt && (idRt == aluRw);
  assign luHaz   = aluMemRd && aluRegWr && (aluRw != 5'd0) && (rsMatch || rtMatch);

  // mfhi/mflo must wait for the result; a new mult must wait for the unit.
  assign mHaz    = multBusy && (idReadsHiLo || idMult);

  // State register: occupancy counter, FSM state and the stall counter.
  always_ff @(posedge clk or negedge regRst) begin
    if (!regRst) begin
      state      <= IDLE;
      cnt        <= '0;
      stallCount <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (pcHold) begin
        stallCount <= stallCount + 32'd1;
      end
    end
  end

  // Next-state logic. The countdown runs independently of stalls and
  // kills: an in-flight multiply belongs to an older instruction.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (multStart) begin
          stateNext = BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      BUSY: begin
        cntNext = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Output logic. A taken branch squashes IF and ID, so nothing in ID may
  // stall the pipe or launch the multiplier in that cycle. Everything is
  // gated by regRst so the pipeline sees no control activity in reset.
  always_comb begin
    pcHold    = 1'b0;
    ifHold    = 1'b0;
    idHold    = 1'b0;
    ifKill    = 1'b0;
    idKill    = 1'b0;
    aluKill   = 1'b0;
    multStart = 1'b0;
    if (regRst) begin
      if (aluBranchTaken) begin
        ifKill = 1'b1;
        idKill = 1'b1;
      end else if (luHaz || mHaz) begin
        pcHold  = 1'b1;
        ifHold  = 1'b1;
        idHold  = 1'b1;
        aluKill = 1'b1;
      end else if (idMult && !multBusy) begin
        multStart = 1'b1;
      end
    end
  end

endmodule
